// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the fetch FSM encoding and the IF/ID bundle.
package fetch_pkg;

  localparam int FETCH_PC_W    = 9;
  localparam int FETCH_INSTR_W = 32;
  localparam int PC_INC        = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_fifo.sv
// Two-entry IF/ID buffer with flush, push/pop and occupancy count.
// Flush wins over a push in the same cycle.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  if_id_t     wdata_i,
  output if_id_t     head_o,
  output logic [1:0] count_o,
  output logic       empty_o
);

  if_id_t     mem_q [2];
  if_id_t     mem_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = ~wr_q;
      end
      if (pop_i) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, single-outstanding imem requests, IF/ID buffer.
// Optional MISALIGN_CHECK_EN adds misalign_o flagging unaligned redirects.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INSTR_W  = FETCH_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    next_pc_i,
  input  logic               redirect_i,
  output logic [PC_W-1:0]    pc_plus4_o,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
`ifdef MISALIGN_CHECK_EN
  output logic               misalign_o,
`endif
  output logic               id_valid_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [INSTR_W-1:0] id_instr_o,
  input  logic               id_ready_i
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] fly_q, fly_d;
  logic            kill_q, kill_d;
  logic            stale_q, stale_d;

  logic            gnt_ok, rsp, push, pop, empty;
  logic [1:0]      cnt, cnt_nxt;
  logic [PC_W-1:0] target;
  if_id_t          wdata, head;

  assign target     = next_pc_i & ~(PC_W'(3));
  assign pc_plus4_o = pc_q + PC_W'(PC_INC);
  assign gnt_ok     = (state_q == REQ) && imem_gnt_i;
  assign rsp        = (state_q == WAIT) && imem_rvalid_i;
  assign push       = rsp && !kill_q && !redirect_i;
  assign pop        = !empty && id_ready_i;
  assign cnt_nxt    = redirect_i ? 2'd0
                    : cnt + 2'(push) - 2'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cnt < 2'd2 && !kill_q) state_d = REQ;
      REQ:  if (imem_gnt_i) state_d = WAIT;
      WAIT: if (imem_rvalid_i)
              state_d = (cnt_nxt < 2'd2) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A redirect during an ungranted request leaves it on the bus
  // at its old address; it is marked stale and killed later.
  always_comb begin
    imem_req_o  = (state_q == REQ);
    imem_addr_o = stale_q ? addr_q : pc_q;
  end

  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    stale_d = stale_q;
    fly_d   = fly_q;
    kill_d  = kill_q;
    if (redirect_i)
      pc_d = target;
    else if (gnt_ok && !stale_q)
      pc_d = pc_q + PC_W'(PC_INC);
    if (gnt_ok) begin
      stale_d = 1'b0;
      fly_d   = imem_addr_o;
    end else if (state_q == REQ && redirect_i && !stale_q) begin
      stale_d = 1'b1;
      addr_d  = pc_q;
    end
    if (rsp)
      kill_d = 1'b0;
    if (redirect_i && (state_q == REQ || (state_q == WAIT && !imem_rvalid_i)))
      kill_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      fly_q   <= RESET_PC;
      stale_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      fly_q   <= fly_d;
      stale_q <= stale_d;
      kill_q  <= kill_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = redirect_i && (next_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`endif

  assign wdata.pc    = fly_q;
  assign wdata.instr = imem_rdata_i;

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (cnt),
    .empty_o (empty)
  );

  assign id_valid_o = !empty;
  assign id_pc_o    = head.pc;
  assign id_instr_o = head.instr;

endmodule
